beat_sequencer: RTL and testbench
=================================

// Module: beat_sequencer
// PURPOSE
//  Records live keyboard notes as (ascii, duration) segments and plays them back.
//  Drives the 7-bit ascii input of the tone rate divider: live passthrough when idle or recording, stored notes during playback.
//  Sits between the PS/2 ascii decoder and rate_divider / rate_divider_no_display.
// PARAMETERS
//  DEPTH     64     segment memory entries; must be a power of 2
//  AW        6      log2(DEPTH)
//  DUR_W     16     duration field width, in ticks
//  TICK_DIV  50000  clk cycles per tick (1 ms at 50 MHz); bench uses 4
// PORTS
//  clk         in   1      system clock, rising edge
//  resetn      in   1      asynchronous reset, active low
//  key_ascii   in   7      live key code from the decoder
//  key_valid   in   1      level: key currently held
//  rec_start   in   1      1-cycle pulse: begin recording
//  play_start  in   1      1-cycle pulse: begin playback
//  stop        in   1      1-cycle pulse: abort or finish the current mode
//  note_ascii  out  7      code to the rate divider; 7'd0 = silence
//  recording   out  1      high in REC
//  playing     out  1      high in PFETCH or PHOLD
//  full        out  1      count == DEPTH
//  count       out  AW+1   number of stored segments
// BEHAVIOUR
//  Reset: state=IDLE; count=0; all outputs 0; tick divider=0; memory contents undefined.
//  Live code: lv = key_valid ? key_ascii : 7'd0.
//  note_ascii: lv in IDLE and REC; mem ascii in PHOLD; 0 in PFETCH. Registered, 1 cycle after the input.
//  Tick: a 1-cycle pulse every TICK_DIV clks. The divider is cleared on every state entry.
//  Command priority in the same cycle: stop > rec_start > play_start.
//  Start pulses are accepted only in IDLE and ignored elsewhere.
//  IDLE:
//   - rec_start: count<=0; cur<=lv; dur<=0; go to REC.
//   - play_start with count!=0: rd_idx<=0; go to PFETCH.
//   - play_start with count==0: stay in IDLE.
//  REC, on each tick:
//   - Sample lv.
//   - If lv==cur, dur<=dur+1.
//   - If lv!=cur, write {cur,dur} at count, count++, cur<=lv, dur<=1.
//   - Saturation: when dur reaches 2^DUR_W-1, write the segment and restart with dur<=0 and the same cur.
//   - Leading silence is recorded as a segment like any other.
//  REC exits:
//   - Memory write that makes count==DEPTH: go to IDLE immediately. full=1; remaining time is discarded.
//   - stop: if dur!=0 and !full, write the final segment. Go to IDLE.
//  Memory: single write port. Synchronous read with 1-cycle latency.
//  PFETCH:
//   - Issue a read at rd_idx.
//   - Next cycle: load ascii and dur into the play registers, go to PHOLD.
//  PHOLD, on each tick: remaining--.
//   - A segment with dur==0 plays for 0 ticks.
//   - remaining==0: rd_idx++. Go to IDLE if rd_idx+1==count, else to PFETCH.
//   - Each segment therefore lasts dur ticks, plus 2 clk of fetch gap, plus divider alignment.
//  stop in PFETCH/PHOLD: go to IDLE next cycle and return note_ascii to lv. count is preserved.
//  reset mid-operation: immediate async return to reset values. The recording is lost (count=0).
//  rd_idx and write address are AW bits and never wrap; a write at count==DEPTH is impossible by construction.
// STRUCTURE
//  Shared package beat_pkg:
//   - state encoding IDLE, REC, PFETCH, PHOLD (2 bits)
//   - NOTE_SILENCE=7'd0
//   - segment width KEY_W+DUR_W=23
//  Sub-module ms_tick:
//   - parameter TICK_DIV
//   - inputs clk, resetn, clr; output tick
//   - counter clears on clr
//  Segment RAM: inferred in beat_sequencer, DEPTH x 23.
// TESTING (TICK_DIV=4)
//  1. Reset, then idle with key_valid=1 and key_ascii=65 -> note_ascii=65 one clk later; recording=0, playing=0, count=0.
//  2. rec_start; hold 'A'(65) for 3 ticks; release for 2 ticks; hold 'S'(83) for 1 tick; stop
//     -> segments {0,0}? no: {65,3},{0,2},{83,1}; count=3; state IDLE.
//  3. play_start after test 2 -> note_ascii sequence 65 for 3 ticks, 0, 83 for 1 tick; playing=1 throughout; then IDLE, playing=0.
//  4. Record DEPTH+5 alternating keys, 1 tick each -> count=64, full=1, recording drops on the 64th write; later changes ignored.
//  5. DUR_W=3, hold 'D'(68) for 10 ticks, then stop -> segments {68,7},{68,3}; playback gives a continuous 68 except 2-clk fetch gaps.
//  6. play_start with count==0 -> stays IDLE. stop mid-PHOLD -> IDLE next clk, count unchanged.
//     resetn low mid-REC -> all outputs 0 asynchronously, count=0.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared definitions for the beat sequencer: FSM states, silence code,
// segment layout and the live-key helper.
package beat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REC    = 2'd1,
    PFETCH = 2'd2,
    PHOLD  = 2'd3
  } state_t;

  localparam int KEY_W = 7;
  localparam int DUR_W_DEFAULT = 16;
  // One stored segment is {ascii, duration}.
  localparam int SEG_W_DEFAULT = KEY_W + DUR_W_DEFAULT;

  localparam logic [KEY_W-1:0] NOTE_SILENCE = 7'd0;

  // A released key reads as silence.
  function automatic logic [KEY_W-1:0] live_code(input logic valid, input logic [KEY_W-1:0] ascii);
    return valid ? ascii : NOTE_SILENCE;
  endfunction

endpackage

// File: rtl/ms_tick.sv
// Free-running tick divider: one-cycle pulse every TICK_DIV clocks,
// restartable so every FSM state starts on a fresh tick boundary.
module ms_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..TICK_DIV-1 and wrap; clr restarts the period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // The cycle carrying clr never ticks, so a stale count cannot leak into a new state.
  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/beat_sequencer.sv
// Records live key codes as (ascii, duration) segments and plays them back
// into the tone rate divider; live passthrough otherwise.
module beat_sequencer
  import beat_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [KEY_W-1:0] key_ascii,
  input  logic             key_valid,
  input  logic             rec_start,
  input  logic             play_start,
  input  logic             stop,
  output logic [KEY_W-1:0] note_ascii,
  output logic             recording,
  output logic             playing,
  output logic             full,
  output logic [AW:0]      count
);

  localparam int SEG_W = KEY_W + DUR_W;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  state_t           state;
  logic [KEY_W-1:0] lv;
  logic [KEY_W-1:0] cur;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] remaining;
  logic [AW-1:0]    rd_idx;
  logic             fetch_wait;
  logic             clr;
  logic             tick;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [SEG_W-1:0] wr_data;
  logic [SEG_W-1:0] rd_data;
  logic [SEG_W-1:0] mem [DEPTH];

  assign lv = live_code(key_valid, key_ascii);

  ms_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr),
    .tick   (tick)
  );

  // Segment store: writes arrive one cycle after the FSM decides them,
  // reads are registered from rd_idx every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

  // Main control FSM with registered outputs; clr is pulsed on every state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      note_ascii <= NOTE_SILENCE;
      recording  <= 1'b0;
      playing    <= 1'b0;
      full       <= 1'b0;
      count      <= '0;
      cur        <= NOTE_SILENCE;
      dur        <= '0;
      remaining  <= '0;
      rd_idx     <= '0;
      fetch_wait <= 1'b0;
      clr        <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      clr   <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          note_ascii <= lv;
          if (!stop && rec_start) begin
            state     <= REC;
            clr       <= 1'b1;
            recording <= 1'b1;
            count     <= '0;
            full      <= 1'b0;
            cur       <= lv;
            dur       <= '0;
          end else if (!stop && play_start && count != '0) begin
            state      <= PFETCH;
            clr        <= 1'b1;
            playing    <= 1'b1;
            rd_idx     <= '0;
            fetch_wait <= 1'b0;
            note_ascii <= NOTE_SILENCE;
          end
        end

        REC: begin
          note_ascii <= lv;
          if (stop) begin
            // Flush the open segment unless it has no time in it yet.
            if (dur != '0 && !full) begin
              wr_en   <= 1'b1;
              wr_addr <= count[AW-1:0];
              wr_data <= {cur, dur};
              count   <= count + 1'b1;
              full    <= (count + 1'b1 == DEPTH_C);
            end
            state     <= IDLE;
            clr       <= 1'b1;
            recording <= 1'b0;
          end else if (tick) begin
            if (lv == cur && dur != DUR_MAX - 1'b1) begin
              dur <= dur + 1'b1;
            end else begin
              // Key change closes the segment; an unchanged key closes it at saturation.
              wr_en   <= 1'b1;
              wr_addr <= count[AW-1:0];
              wr_data <= {cur, (lv == cur) ? DUR_MAX : dur};
              count   <= count + 1'b1;
              if (lv == cur) begin
                dur <= '0;
              end else begin
                cur <= lv;
                dur <= DUR_W'(1);
              end
              if (count + 1'b1 == DEPTH_C) begin
                full      <= 1'b1;
                state     <= IDLE;
                clr       <= 1'b1;
                recording <= 1'b0;
              end
            end
          end
        end

        PFETCH: begin
          note_ascii <= NOTE_SILENCE;
          if (stop) begin
            state      <= IDLE;
            clr        <= 1'b1;
            playing    <= 1'b0;
            note_ascii <= lv;
          end else if (!fetch_wait) begin
            // First cycle: the RAM is still reading the new rd_idx.
            fetch_wait <= 1'b1;
          end else begin
            fetch_wait <= 1'b0;
            state      <= PHOLD;
            clr        <= 1'b1;
            note_ascii <= rd_data[SEG_W-1:DUR_W];
            remaining  <= rd_data[DUR_W-1:0];
          end
        end

        PHOLD: begin
          if (stop) begin
            state      <= IDLE;
            clr        <= 1'b1;
            playing    <= 1'b0;
            note_ascii <= lv;
          end else if (remaining == '0) begin
            clr <= 1'b1;
            if ({1'b0, rd_idx} + 1'b1 == count) begin
              state      <= IDLE;
              playing    <= 1'b0;
              note_ascii <= lv;
            end else begin
              rd_idx     <= rd_idx + 1'b1;
              state      <= PFETCH;
              note_ascii <= NOTE_SILENCE;
            end
          end else if (tick) begin
            remaining <= remaining - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed bench for beat_sequencer with TICK_DIV=4: a wide-duration instance
// and a DUR_W=3 instance share the same stimulus.
module tb_beat_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [6:0] key_ascii = 7'd0;
  logic       key_valid = 1'b0;
  logic       rec_start = 1'b0;
  logic       play_start = 1'b0;
  logic       stop = 1'b0;

  logic [6:0] note1, note2;
  logic       rec1, rec2, play1, play2, full1, full2;
  logic [6:0] count1, count2;

  int vectors = 0;
  int miscompares = 0;

  // run-length capture of note_ascii while playing, per instance
  int rv [2][32];
  int rl [2][32];
  int nr [2];

  typedef struct {
    logic       kv;
    logic [6:0] ka;
    logic [6:0] exp_note;
  } live_vec_t;

  live_vec_t tbl [6];

  always #5 clk = ~clk;

  beat_sequencer #(.DEPTH(64), .AW(6), .DUR_W(16), .TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .key_ascii(key_ascii), .key_valid(key_valid),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .note_ascii(note1), .recording(rec1), .playing(play1), .full(full1), .count(count1)
  );

  beat_sequencer #(.DEPTH(64), .AW(6), .DUR_W(3), .TICK_DIV(4)) dut_sat (
    .clk(clk), .resetn(resetn), .key_ascii(key_ascii), .key_valid(key_valid),
    .rec_start(rec_start), .play_start(play_start), .stop(stop),
    .note_ascii(note2), .recording(rec2), .playing(play2), .full(full2), .count(count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1;
    clks(1);
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    clks(1);
    stop = 1'b0;
  endtask

  task automatic push(input int w, input int v);
    if (nr[w] > 0 && rv[w][nr[w]-1] == v) begin
      rl[w][nr[w]-1] = rl[w][nr[w]-1] + 1;
    end else if (nr[w] < 32) begin
      rv[w][nr[w]] = v;
      rl[w][nr[w]] = 1;
      nr[w] = nr[w] + 1;
    end
  endtask

  // Start playback and record note runs on both instances until both stop playing.
  task automatic play_capture(input int max_cycles);
    nr[0] = 0;
    nr[1] = 0;
    play_start = 1'b1;
    @(posedge clk);
    #1;
    play_start = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (!play1 && !play2) break;
      if (play1) push(0, int'(note1));
      if (play2) push(1, int'(note2));
    end
    check("play_done", {30'd0, play1, play2}, 32'd0);
    #1;
  endtask

  task automatic check_runs(input string name, input int w, input int ev[4], input int el[4], input int n);
    check({name, "_nruns"}, nr[w], n);
    for (int i = 0; i < n && i < nr[w]; i++) begin
      check($sformatf("%s_val%0d", name, i), rv[w][i], ev[i]);
      check($sformatf("%s_len%0d", name, i), rl[w][i], el[i]);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 7'd65,  7'd65};
    tbl[1] = '{1'b0, 7'd65,  7'd0};
    tbl[2] = '{1'b1, 7'd83,  7'd83};
    tbl[3] = '{1'b1, 7'd127, 7'd127};
    tbl[4] = '{1'b0, 7'd0,   7'd0};
    tbl[5] = '{1'b1, 7'd1,   7'd1};

    // ---- reset state
    clks(3);
    check("rst_note", note1, 0);
    check("rst_rec", rec1, 0);
    check("rst_play", play1, 0);
    check("rst_full", full1, 0);
    check("rst_count", count1, 0);
    #2 resetn = 1'b1;
    clks(2);

    // ---- test 1: live passthrough in IDLE, table driven
    for (int i = 0; i < 6; i++) begin
      key_valid = tbl[i].kv;
      key_ascii = tbl[i].ka;
      clks(1);
      check($sformatf("live%0d_note", i), note1, tbl[i].exp_note);
      check($sformatf("live%0d_state", i), {rec1, play1, count1}, 0);
    end

    // stop outranks rec_start in the same cycle
    rec_start = 1'b1;
    stop = 1'b1;
    clks(1);
    rec_start = 1'b0;
    stop = 1'b0;
    clks(1);
    check("prio_stop_rec", rec1, 0);

    // ---- test 2: record A x3 ticks, silence x2, S x1
    key_valid = 1'b1;
    key_ascii = 7'd65;
    pulse_rec();              // accepted at E0, now E0+1
    clks(2);
    check("t2_recording", rec1, 1);
    check("t2_note_live", note1, 65);
    clks(11);                 // E0+14, after the third tick
    key_valid = 1'b0;
    clks(8);                  // E0+22
    key_valid = 1'b1;
    key_ascii = 7'd83;
    clks(4);                  // E0+26, after the sixth tick
    pulse_stop();
    clks(1);
    check("t2_count", count1, 3);
    check("t2_rec_off", rec1, 0);
    check("t2_full", full1, 0);

    // ---- test 3: playback of {65,3},{0,2},{83,1}
    key_valid = 1'b0;
    play_capture(200);
    check_runs("t3", 0, '{0, 65, 0, 83}, '{2, 14, 14, 6}, 4);
    check("t3_note_after", note1, 0);
    check("t3_count_kept", count1, 3);

    // ---- test 4: fill memory with alternating keys, one tick each
    key_valid = 1'b1;
    key_ascii = 7'd65;
    pulse_rec();
    clks(2);                  // E0+3
    for (int j = 0; j < 69; j++) begin
      if (j == 63) begin
        check("t4_count63", count1, 63);
        check("t4_rec_before_full", rec1, 1);
      end
      key_ascii = (j % 2 == 0) ? 7'd66 : 7'd67;
      clks(4);
    end
    check("t4_count", count1, 64);
    check("t4_full", full1, 1);
    check("t4_rec_off", rec1, 0);
    check("t4_count_sat_dut", count2, 64);
    check("t4_note_live", note1, 66);

    // ---- test 5: hold D for 10 ticks; DUR_W=3 instance saturates at 7
    key_ascii = 7'd68;
    key_valid = 1'b1;
    pulse_rec();              // E0+1
    check("t5_full_cleared", full1, 0);
    clks(41);                 // E0+42, after the tenth tick
    pulse_stop();
    clks(1);
    check("t5_count_wide", count1, 1);
    check("t5_count_sat", count2, 2);
    key_valid = 1'b0;
    play_capture(200);
    check_runs("t5w", 0, '{0, 68, 0, 0}, '{2, 42, 0, 0}, 2);
    check_runs("t5s", 1, '{0, 68, 0, 68}, '{2, 30, 2, 14}, 4);

    // ---- test 6a: stop mid-PHOLD
    play_start = 1'b1;
    clks(1);
    play_start = 1'b0;
    clks(10);
    check("t6_in_play", play1, 1);
    check("t6_note_hold", note1, 68);
    key_valid = 1'b1;
    key_ascii = 7'd70;
    pulse_stop();
    check("t6_play_off", play1, 0);
    check("t6_play_off_sat", play2, 0);
    check("t6_note_live", note1, 70);
    check("t6_count_kept", count1, 1);
    check("t6_count_kept_sat", count2, 2);

    // ---- test 6b: async reset mid-REC
    pulse_rec();
    clks(6);
    check("t6_rec_on", rec1, 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_note", note1, 0);
    check("t6_rst_rec", rec1, 0);
    check("t6_rst_count", count1, 0);
    check("t6_rst_count_sat", count2, 0);
    check("t6_rst_flags", {play1, full1}, 0);
    clks(1);
    #2 resetn = 1'b1;
    clks(1);

    // ---- test 6c: play_start with nothing recorded
    key_valid = 1'b0;
    play_start = 1'b1;
    clks(1);
    play_start = 1'b0;
    check("t6_empty_play", play1, 0);
    clks(3);
    check("t6_empty_play_later", play1, 0);
    check("t6_empty_count", count1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
